// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, stall causes
// and the packed control word driven to the pipeline registers.
package pipe_ctrl_pkg;

    localparam int unsigned MDU_LATENCY_DEFAULT = 8;

    typedef enum logic [1:0] {
        RUN,
        MDU_BUSY,
        MDU_HOLD
    } state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_LOADUSE,
        CAUSE_REDIRECT,
        CAUSE_MDU,
        CAUSE_MEM
    } stall_cause_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
        logic mdu_done;
    } ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline-register controls between the sequencer and the core.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             load_use_stall;
    logic             ex_redirect;
    logic             ex_mdu_start;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic             mdu_done;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  load_use_stall, ex_redirect, ex_mdu_start, dmem_req, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               mdu_done, stall_cycles
    );

    modport slave (
        output load_use_stall, ex_redirect, ex_mdu_start, dmem_req, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               mdu_done, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core: arbitrates memory wait, MDU occupancy,
// branch redirect and load-use hazard, and counts stalled cycles.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEFAULT,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.master  bus
);
    localparam int unsigned MCW = $clog2(MDU_LATENCY);

    state_t         state, state_d;
    logic [MCW-1:0] mdu_cnt, mdu_cnt_d;
    stall_cause_t   cause;
    ctrl_t          ctrl;
    logic           mem_wait;
    logic           mdu_done;
    logic           mdu_busy;
    logic [CNT_W-1:0] stall_cnt;

    assign mem_wait = bus.dmem_req & ~bus.dmem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            mdu_cnt <= '0;
        end else begin
            state   <= state_d;
            mdu_cnt <= mdu_cnt_d;
        end
    end

    // A redirect in the same cycle as an MDU start wins; the MDU op is dropped.
    always_comb begin
        state_d   = state;
        mdu_cnt_d = mdu_cnt;
        unique case (state)
            RUN: begin
                if (bus.ex_mdu_start && !bus.ex_redirect) begin
                    state_d   = MDU_BUSY;
                    mdu_cnt_d = MCW'(MDU_LATENCY - 1);
                end
            end
            MDU_BUSY: begin
                mdu_cnt_d = mdu_cnt - MCW'(1);
                if (mdu_cnt == MCW'(1)) begin
                    state_d = mem_wait ? MDU_HOLD : RUN;
                end
            end
            MDU_HOLD: begin
                if (!mem_wait) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Priority encode the live stall cause and expand it into the control word.
    always_comb begin
        ctrl     = '0;
        cause    = CAUSE_NONE;
        mdu_done = !mem_wait && (((state == MDU_BUSY) && (mdu_cnt == MCW'(1)))
                                 || (state == MDU_HOLD));
        mdu_busy = ((state == RUN) && bus.ex_mdu_start && !bus.ex_redirect)
                 || ((state != RUN) && !mdu_done);

        if (mem_wait)                cause = CAUSE_MEM;
        else if (mdu_busy)           cause = CAUSE_MDU;
        else if (bus.ex_redirect)    cause = CAUSE_REDIRECT;
        else if (bus.load_use_stall) cause = CAUSE_LOADUSE;

        unique case (cause)
            CAUSE_MEM: begin
                ctrl.mem_wb_flush = 1'b1;
            end
            CAUSE_MDU: begin
                ctrl.ex_mem_en    = 1'b1;
                ctrl.ex_mem_flush = 1'b1;
                ctrl.mem_wb_en    = 1'b1;
            end
            CAUSE_REDIRECT: begin
                ctrl.pc_en       = 1'b1;
                ctrl.if_id_en    = 1'b1;
                ctrl.id_ex_en    = 1'b1;
                ctrl.ex_mem_en   = 1'b1;
                ctrl.mem_wb_en   = 1'b1;
                ctrl.if_id_flush = 1'b1;
                ctrl.id_ex_flush = 1'b1;
            end
            CAUSE_LOADUSE: begin
                ctrl.id_ex_en    = 1'b1;
                ctrl.ex_mem_en   = 1'b1;
                ctrl.mem_wb_en   = 1'b1;
                ctrl.id_ex_flush = 1'b1;
            end
            default: begin
                ctrl.pc_en     = 1'b1;
                ctrl.if_id_en  = 1'b1;
                ctrl.id_ex_en  = 1'b1;
                ctrl.ex_mem_en = 1'b1;
                ctrl.mem_wb_en = 1'b1;
            end
        endcase
        ctrl.mdu_done = mdu_done;

        if (rst) begin
            ctrl              = '0;
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
            ctrl.ex_mem_flush = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.ex_redirect && bus.ex_mdu_start))
                else $error("pipeline_ctrl: ex_redirect and ex_mdu_start both high");
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (!ctrl.pc_en && !rst),
        .count (stall_cnt)
    );

    assign bus.pc_en        = ctrl.pc_en;
    assign bus.if_id_en     = ctrl.if_id_en;
    assign bus.id_ex_en     = ctrl.id_ex_en;
    assign bus.ex_mem_en    = ctrl.ex_mem_en;
    assign bus.mem_wb_en    = ctrl.mem_wb_en;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_flush  = ctrl.id_ex_flush;
    assign bus.ex_mem_flush = ctrl.ex_mem_flush;
    assign bus.mem_wb_flush = ctrl.mem_wb_flush;
    assign bus.mdu_done     = ctrl.mdu_done;
    assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: priority arbitration, MDU timing, memory hold,
// counter saturation (narrow counter) and reset during an MDU op.
module tb_pipeline_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int unsigned CW = 4;

    // {pc,if_id,id_ex,ex_mem,mem_wb en, if_id,id_ex,ex_mem,mem_wb flush, mdu_done}
    localparam logic [9:0] V_NONE  = 10'b11111_0000_0;
    localparam logic [9:0] V_LU    = 10'b00111_0100_0;
    localparam logic [9:0] V_RDR   = 10'b11111_1100_0;
    localparam logic [9:0] V_MDU   = 10'b00011_0010_0;
    localparam logic [9:0] V_MEM   = 10'b00000_0001_0;
    localparam logic [9:0] V_RST   = 10'b00000_1111_0;
    localparam logic [9:0] V_DONE  = 10'b11111_0000_1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [9:0] obs;

    pipeline_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_ctrl #(.MDU_LATENCY(8), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    assign obs = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                  bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush,
                  bus.mdu_done};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // One cycle: drive at negedge, check outputs and counter, advance counter model.
    task automatic step(input logic lu, input logic rd, input logic ms, input logic dr,
                        input logic dy, input logic [9:0] ev, input string tag);
        @(negedge clk);
        bus.load_use_stall = lu;
        bus.ex_redirect    = rd;
        bus.ex_mdu_start   = ms;
        bus.dmem_req       = dr;
        bus.dmem_ready     = dy;
        #1;
        chk(tag, 32'(obs), 32'(ev));
        chk({tag, "_cnt"}, 32'(bus.stall_cycles), 32'(exp_cnt));
        if (!ev[9] && (exp_cnt != '1)) exp_cnt = exp_cnt + CW'(1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        bus.load_use_stall = 1'b0;
        bus.ex_redirect    = 1'b0;
        bus.ex_mdu_start   = 1'b0;
        bus.dmem_req       = 1'b0;
        bus.dmem_ready     = 1'b0;
        rst = 1'b1;
        #1;
        chk(tag, 32'(obs), 32'(V_RST));
        exp_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.load_use_stall = 1'b0;
        bus.ex_redirect    = 1'b0;
        bus.ex_mdu_start   = 1'b0;
        bus.dmem_req       = 1'b0;
        bus.dmem_ready     = 1'b0;
        #1;
        chk("reset_ctrl", 32'(obs), 32'(V_RST));
        chk("reset_cnt", 32'(bus.stall_cycles), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load-use alone, then redirect masking load-use, then memory over everything
        step(0, 0, 0, 0, 0, V_NONE, "idle");
        step(1, 0, 0, 0, 0, V_LU,   "load_use");
        step(0, 0, 0, 0, 0, V_NONE, "after_lu");
        step(1, 1, 0, 0, 0, V_RDR,  "redirect_over_lu");
        step(0, 0, 0, 0, 0, V_NONE, "after_rdr");
        step(1, 1, 0, 1, 0, V_MEM,  "mem_over_all");
        step(0, 0, 0, 1, 1, V_NONE, "dmem_ready_no_wait");

        // MDU op, latency 8: stall t0..t6, done at t7, back to RUN at t8
        step(0, 0, 1, 0, 0, V_MDU, "mdu_t0");
        for (int i = 1; i <= 6; i++) begin
            step((i == 2), 0, (i == 3), 0, 0, V_MDU, "mdu_busy");
        end
        step(0, 0, 0, 0, 0, V_DONE, "mdu_done_t7");
        step(0, 0, 0, 0, 0, V_NONE, "mdu_t8");
        checks++;
        assert (dut.state === RUN) else begin
            errors++;
            $error("FAIL mdu_state_run: observed %0d expected %0d", dut.state, RUN);
        end

        // MDU op held by memory wait t5..t10, done at t11
        do_reset("reset_before_hold");
        step(0, 0, 1, 0, 0, V_MDU, "hold_t0");
        for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 0, V_MDU, "hold_busy");
        for (int i = 5; i <= 10; i++) begin
            step((i == 9), 0, 0, 1, 0, V_MEM, "hold_memwait");
            if (i == 8) begin
                checks++;
                assert (dut.state === MDU_HOLD) else begin
                    errors++;
                    $error("FAIL hold_state: observed %0d expected %0d", dut.state, MDU_HOLD);
                end
            end
        end
        step(0, 0, 0, 1, 1, V_DONE, "hold_done_t11");
        step(0, 0, 0, 0, 0, V_NONE, "hold_t12");
        step(1, 0, 0, 0, 0, V_LU,   "lu_after_hold");

        // Saturation of the 4-bit stall counter
        do_reset("reset_before_sat");
        for (int i = 0; i < 17; i++) step(1, 0, 0, 0, 0, V_LU, "sat_stall");
        step(0, 0, 0, 0, 0, V_NONE, "sat_final");
        chk("sat_all_ones", 32'(bus.stall_cycles), 32'hF);

        // Reset in the middle of an MDU op: no done ever afterwards
        do_reset("reset_before_abort");
        step(0, 0, 1, 0, 0, V_MDU, "abort_t0");
        step(0, 0, 0, 0, 0, V_MDU, "abort_t1");
        step(0, 0, 0, 0, 0, V_MDU, "abort_t2");
        do_reset("abort_rst_t3");
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, V_NONE, "abort_no_done");
        checks++;
        assert (dut.state === RUN) else begin
            errors++;
            $error("FAIL abort_state: observed %0d expected %0d", dut.state, RUN);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
